// File: rtl/wb_stage_seq.sv
// Writeback/commit stage: retires one instruction per cycle into the RF/CP0, sequences
// multi-cycle TLB ops over a req/ack handshake and raises flush/redirect on ex, eret, refetch.
module wb_stage_seq #(
  parameter int          DATA_W    = 32,
  parameter int          RF_ADDR_W = 5,
  parameter int          STRB_W    = 4,
  parameter logic [31:0] EX_VEC    = 32'hBFC00380,
  parameter int          TLB_TMO   = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic [DATA_W-1:0]    ms_result,
  input  logic [RF_ADDR_W-1:0] ms_dest,
  input  logic [STRB_W-1:0]    ms_strb,
  input  logic                 ms_ex,
  input  logic [4:0]           ms_excode,
  input  logic                 ms_eret,
  input  logic [1:0]           ms_tlb_op,
  input  logic                 ms_refetch,
  input  logic [31:0]          cp0_epc,
  output logic                 tlb_req,
  output logic [1:0]           tlb_op,
  input  logic                 tlb_ack,
  output logic [STRB_W-1:0]    rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 ex_commit,
  output logic [4:0]           ex_code,
  output logic                 flush,
  output logic [31:0]          flush_pc,
  output logic [RF_ADDR_W-1:0] ws_dest_busy,
  output logic                 tlb_abort,
  output logic [31:0]          debug_wb_pc,
  output logic [STRB_W-1:0]    debug_wb_rf_wen,
  output logic [RF_ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int                CNT_W    = (TLB_TMO > 2) ? $clog2(TLB_TMO) : 1;
  localparam bit                TMO_EN   = (TLB_TMO > 0);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'((TLB_TMO > 0) ? TLB_TMO - 1 : 0);

  // Redirect target by priority: exception vector, then EPC for eret, else refetch own PC.
  function automatic logic [31:0] redirect_pc(input logic        ex,
                                              input logic        eret,
                                              input logic [31:0] epc,
                                              input logic [31:0] pc);
    if (ex)        redirect_pc = EX_VEC;
    else if (eret) redirect_pc = epc;
    else           redirect_pc = pc;
  endfunction

  logic                 ws_valid_q, ws_valid_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 abort_q, abort_d;

  logic [31:0]          pc_q, pc_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [RF_ADDR_W-1:0] dest_q, dest_d;
  logic [STRB_W-1:0]    strb_q, strb_d;
  logic                 ex_q, ex_d;
  logic [4:0]           excode_q, excode_d;
  logic                 eret_q, eret_d;
  logic [1:0]           tlb_op_q, tlb_op_d;
  logic                 refetch_q, refetch_d;

  logic ws_ready_go;
  logic tlb_pending;
  logic commit;
  logic capture;

  always_comb begin
    tlb_pending = ws_valid_q & (tlb_op_q != 2'b00) & ~ex_q;
    ws_ready_go = 1'b1;
    if (state_q == ST_WAIT)                     ws_ready_go = 1'b0;
    else if (state_q == ST_IDLE && tlb_pending) ws_ready_go = 1'b0;
    ws_allowin = ~ws_valid_q | ws_ready_go;
    commit     = ws_valid_q & ws_ready_go;
    flush      = commit & (ex_q | eret_q | refetch_q);
    capture    = ws_allowin & ms_to_ws_valid & ~flush;
  end

  // Stage boundary: MEM -> WB capture; the slot empties on commit unless refilled.
  always_comb begin
    ws_valid_d = ws_valid_q;
    pc_d       = pc_q;
    result_d   = result_q;
    dest_d     = dest_q;
    strb_d     = strb_q;
    ex_d       = ex_q;
    excode_d   = excode_q;
    eret_d     = eret_q;
    tlb_op_d   = tlb_op_q;
    refetch_d  = refetch_q;
    if (capture) begin
      ws_valid_d = 1'b1;
      pc_d       = ms_pc;
      result_d   = ms_result;
      dest_d     = ms_dest;
      strb_d     = ms_strb;
      ex_d       = ms_ex;
      excode_d   = ms_excode;
      eret_d     = ms_eret;
      tlb_op_d   = ms_tlb_op;
      refetch_d  = ms_refetch;
    end else if (commit) begin
      ws_valid_d = 1'b0;
    end
  end

  // TLB sequencer: a stray ack outside TLB_WAIT falls through the default hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tlb_pending) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (tlb_ack) begin
          state_d = ST_DONE;
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          state_d = ST_DONE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      pc_q       <= '0;
      result_q   <= '0;
      dest_q     <= '0;
      strb_q     <= '0;
      ex_q       <= 1'b0;
      excode_q   <= '0;
      eret_q     <= 1'b0;
      tlb_op_q   <= 2'b00;
      refetch_q  <= 1'b0;
    end else begin
      ws_valid_q <= ws_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      pc_q       <= pc_d;
      result_q   <= result_d;
      dest_q     <= dest_d;
      strb_q     <= strb_d;
      ex_q       <= ex_d;
      excode_q   <= excode_d;
      eret_q     <= eret_d;
      tlb_op_q   <= tlb_op_d;
      refetch_q  <= refetch_d;
    end
  end

  // Stage boundary: WB -> RF / CP0 / front-end redirect.
  always_comb begin
    tlb_req      = (state_q == ST_WAIT);
    tlb_op       = tlb_req ? tlb_op_q : 2'b00;
    tlb_abort    = abort_q;
    rf_we        = (commit & ~ex_q) ? strb_q : '0;
    rf_waddr     = dest_q;
    rf_wdata     = result_q;
    ex_commit    = commit & ex_q;
    ex_code      = ex_commit ? excode_q : 5'd0;
    flush_pc     = flush ? redirect_pc(ex_q, eret_q, cp0_epc, pc_q) : 32'd0;
    ws_dest_busy = ws_valid_q ? dest_q : '0;
    debug_wb_pc       = pc_q;
    debug_wb_rf_wen   = rf_we;
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

endmodule

// File: tb/tb_wb_stage_seq.sv
// Directed bench for wb_stage_seq: stimulus pushes expected commits, a monitor pops and compares.
module tb_wb_stage_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ms_to_ws_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] ms_pc = '0;
  logic [31:0] ms_result = '0;
  logic [4:0]  ms_dest = '0;
  logic [3:0]  ms_strb = '0;
  logic        ms_ex = 1'b0;
  logic [4:0]  ms_excode = '0;
  logic        ms_eret = 1'b0;
  logic [1:0]  ms_tlb_op = '0;
  logic        ms_refetch = 1'b0;
  logic [31:0] cp0_epc = '0;
  logic        tlb_req;
  logic [1:0]  tlb_op;
  logic        tlb_ack = 1'b0;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ex_commit;
  logic [4:0]  ex_code;
  logic        flush;
  logic [31:0] flush_pc;
  logic [4:0]  ws_dest_busy;
  logic        tlb_abort;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exc;
    logic [4:0]  code;
    logic        fl;
    logic [31:0] fpc;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];

  wb_stage_seq #(
    .DATA_W(32), .RF_ADDR_W(5), .STRB_W(4), .EX_VEC(32'hBFC00380), .TLB_TMO(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_strb(ms_strb),
    .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_eret(ms_eret), .ms_tlb_op(ms_tlb_op),
    .ms_refetch(ms_refetch), .cp0_epc(cp0_epc),
    .tlb_req(tlb_req), .tlb_op(tlb_op), .tlb_ack(tlb_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ex_commit(ex_commit), .ex_code(ex_code), .flush(flush), .flush_pc(flush_pc),
    .ws_dest_busy(ws_dest_busy), .tlb_abort(tlb_abort),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] we, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic exc, input logic [4:0] code, input logic fl,
                      input logic [31:0] fpc, input logic [31:0] pc);
    ev_t e;
    e.we = we; e.waddr = waddr; e.wdata = wdata; e.exc = exc;
    e.code = code; e.fl = fl; e.fpc = fpc; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                       input logic [3:0] strb, input logic ex, input logic [4:0] code,
                       input logic eret, input logic [1:0] op, input logic rfe);
    ms_pc = pc; ms_result = res; ms_dest = dest; ms_strb = strb; ms_ex = ex;
    ms_excode = code; ms_eret = eret; ms_tlb_op = op; ms_refetch = rfe;
    ms_to_ws_valid = 1'b1;
  endtask

  // Present one instruction and hold it until WB takes it; returns just after the capture edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                      input logic [3:0] strb, input logic ex, input logic [4:0] code,
                      input logic eret, input logic [1:0] op, input logic rfe);
    bit got = 0;
    drive(pc, res, dest, strb, ex, code, eret, op, rfe);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ws_allowin && !flush) got = 1;
      step();
      if (got) break;
    end
    ms_to_ws_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_capture: pc %h not accepted, required acceptance within 40 cycles", pc);
    end
  endtask

  // Follow a TLB op: count req cycles, ack after ack_after of them (0 = never); ends at DONE negedge.
  task automatic run_tlb(input int ack_after, input logic [1:0] op, output int req_cnt);
    bit done = 0;
    req_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tlb_req) begin
        req_cnt++;
        check("allowin_in_wait", {31'd0, ws_allowin}, 32'd0);
        check("tlb_op_in_wait", {30'd0, tlb_op}, {30'd0, op});
        if (req_cnt == ack_after) tlb_ack = 1'b1;
      end else if (req_cnt > 0) begin
        done = 1;
        break;
      end
      step();
      tlb_ack = 1'b0;
    end
    tlb_ack = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL tlb_seq_end: got %0d req cycles without DONE, required DONE within 30 cycles", req_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && (rf_we != 4'd0 || flush || ex_commit)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got pc %h we %h flush %b ex %b, required no commit",
                 debug_wb_pc, rf_we, flush, ex_commit);
      end else begin
        ev_t e;
        bit ok;
        e = exp_q.pop_front();
        ok = (rf_we == e.we) && (ex_commit == e.exc) && (ex_code == e.code) &&
             (flush == e.fl) && (flush_pc == e.fpc) && (debug_wb_pc == e.pc) &&
             (debug_wb_rf_wen == e.we);
        if (e.we != 4'd0)
          ok = ok && (rf_waddr == e.waddr) && (rf_wdata == e.wdata) &&
               (debug_wb_rf_wnum == e.waddr) && (debug_wb_rf_wdata == e.wdata);
        if (!ok) begin
          errors++;
          $display("FAIL commit_%h: got we=%h a=%0d d=%h ex=%b c=%h fl=%b fpc=%h pc=%h, required we=%h a=%0d d=%h ex=%b c=%h fl=%b fpc=%h pc=%h",
                   e.pc, rf_we, rf_waddr, rf_wdata, ex_commit, ex_code, flush, flush_pc, debug_wb_pc,
                   e.we, e.waddr, e.wdata, e.exc, e.code, e.fl, e.fpc, e.pc);
        end
      end
    end
  end

  initial begin
    int n;
    int seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", {31'd0, ws_allowin}, 32'd1);
    check("rst_tlb_req", {31'd0, tlb_req}, 32'd0);
    check("rst_rf_we", {28'd0, rf_we}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_dest_busy", {27'd0, ws_dest_busy}, 32'd0);
    check("rst_debug_pc", debug_wb_pc, 32'd0);
    check("rst_abort", {31'd0, tlb_abort}, 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Plain RF write, then dest_busy in its commit cycle
    push(4'hF, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0010);
    send(32'hBFC0_0010, 32'h0000_1234, 5'd5, 4'hF, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    check("dest_busy", {27'd0, ws_dest_busy}, 32'd5);
    step();

    // Back-to-back instructions
    push(4'h3, 5'd6, 32'hAAAA_5555, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0014);
    push(4'h1, 5'd7, 32'h0000_BEEF, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0018);
    send(32'hBFC0_0014, 32'hAAAA_5555, 5'd6, 4'h3, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    send(32'hBFC0_0018, 32'h0000_BEEF, 5'd7, 4'h1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    step();

    // tlbwi + refetch, ack on the 3rd req cycle
    push(4'h0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hBFC0_0020, 32'hBFC0_0020);
    send(32'hBFC0_0020, 32'd0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0, 2'b11, 1'b1);
    run_tlb(3, 2'b11, n);
    check("tlbwi_req_cycles", n, 32'd3);
    check("tlbwi_no_abort", {31'd0, tlb_abort}, 32'd0);
    step();

    // tlbp with RF write, immediate ack
    push(4'hF, 5'd9, 32'h0000_0077, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0024);
    send(32'hBFC0_0024, 32'h0000_0077, 5'd9, 4'hF, 1'b0, 5'd0, 1'b0, 2'b01, 1'b0);
    run_tlb(1, 2'b01, n);
    check("tlbp_req_cycles", n, 32'd1);
    step();

    // Exception overrides RF write and TLB op
    push(4'h0, 5'd0, 32'd0, 1'b1, 5'h08, 1'b1, 32'hBFC0_0380, 32'hBFC0_0030);
    send(32'hBFC0_0030, 32'h0000_5555, 5'd4, 4'hF, 1'b1, 5'h08, 1'b0, 2'b11, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tlb_req) seen++;
      step();
    end
    check("ex_no_tlb_req", seen, 32'd0);

    // eret; an instruction offered during the flush cycle is dropped
    cp0_epc = 32'h8000_1000;
    push(4'h0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h8000_1000, 32'hBFC0_0040);
    send(32'hBFC0_0040, 32'd0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b1, 2'b00, 1'b0);
    drive(32'hBFC0_0044, 32'h0000_0999, 5'd3, 4'hF, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    check("eret_flush", {31'd0, flush}, 32'd1);
    step();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("eret_drop_busy", {27'd0, ws_dest_busy}, 32'd0);
    step();

    // Stray ack while idle, then a normal instruction
    tlb_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_req", {31'd0, tlb_req}, 32'd0);
    step();
    tlb_ack = 1'b0;
    push(4'hF, 5'd2, 32'hCAFE_0001, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0048);
    send(32'hBFC0_0048, 32'hCAFE_0001, 5'd2, 4'hF, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    step();

    // tlbr with no ack: timeout after 4 req cycles
    push(4'hF, 5'd10, 32'h0000_ABCD, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0050);
    send(32'hBFC0_0050, 32'h0000_ABCD, 5'd10, 4'hF, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0);
    run_tlb(0, 2'b10, n);
    check("tmo_req_cycles", n, 32'd4);
    check("tmo_abort", {31'd0, tlb_abort}, 32'd1);
    check("tmo_done_allowin", {31'd0, ws_allowin}, 32'd1);
    step();
    @(negedge clk);
    check("tmo_abort_pulse", {31'd0, tlb_abort}, 32'd0);
    check("tmo_idle_req", {31'd0, tlb_req}, 32'd0);
    step();

    // Async reset in TLB_WAIT
    send(32'hBFC0_0060, 32'd0, 5'd0, 4'h0, 1'b0, 5'd0, 1'b0, 2'b11, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tlb_req) begin
        seen = 1;
        break;
      end
      step();
    end
    check("rstw_req_seen", seen, 32'd1);
    resetn = 1'b0;
    #1;
    check("rstw_tlb_req", {31'd0, tlb_req}, 32'd0);
    check("rstw_rf_we", {28'd0, rf_we}, 32'd0);
    check("rstw_flush", {31'd0, flush}, 32'd0);
    check("rstw_allowin", {31'd0, ws_allowin}, 32'd1);
    step();
    resetn = 1'b1;
    push(4'hF, 5'd1, 32'h0000_600D, 1'b0, 5'd0, 1'b0, 32'd0, 32'hBFC0_0070);
    send(32'hBFC0_0070, 32'h0000_600D, 5'd1, 4'hF, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    repeat (4) step();

    check("pending_expected", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
